nco_clkgen: RTL and testbench

NCO_CLKGEN -- requirements
Module: nco_clkgen

---
 rtl/nco_clkgen.sv | 117 +++++++++++
 tb/tb_nco_clkgen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_clkgen.sv
// Numerically controlled clock generator: phase accumulator with glitch-free
// registered clock outputs, safe frequency-word handover at wrap, and graceful stop.
module nco_clkgen #(
  parameter int unsigned      ACC_W      = 32,
  parameter logic [ACC_W-1:0] DEFAULT_FW = ACC_W'(32'h0800_0000)
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] freq_word,
  input  logic             freq_load,
  output logic             freq_ack,
  output logic             clk_out,
  output logic             clk_out_8x,
  output logic             wrap,
  output logic             running,
  output logic [15:0]      edge_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] fw_active;
  logic [ACC_W-1:0] pend_word;
  logic             pend_vld;
  logic             carry;
  logic             fw_zero;
  logic             wrap_nxt;
  logic             apply;

  function automatic logic [ACC_W:0] phase_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign fw_zero = (fw_active == '0);

  // Next-phase computation: everything below is registered on the same edge.
  always_comb begin
    {carry, sum} = phase_add(acc, fw_active);
    state_nxt    = state;
    acc_nxt      = acc;
    wrap_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        acc_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        acc_nxt  = sum;
        wrap_nxt = carry;
        if (!enable) state_nxt = STOPPING;
      end
      STOPPING: begin
        if (enable) begin
          // Resume keeps the running phase, so the output period is unbroken.
          acc_nxt   = sum;
          wrap_nxt  = carry;
          state_nxt = RUN;
        end else if (fw_zero || carry) begin
          acc_nxt   = '0;
          wrap_nxt  = carry;
          state_nxt = IDLE;
        end else begin
          acc_nxt = sum;
        end
      end
      default: begin
        acc_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
    // A stalled accumulator (zero word) never wraps, so it takes a new word at once.
    apply = pend_vld && (wrap_nxt || (state == IDLE) || ((state == RUN) && fw_zero));
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      fw_active  <= DEFAULT_FW;
      pend_vld   <= 1'b0;
      freq_ack   <= 1'b0;
      clk_out    <= 1'b0;
      clk_out_8x <= 1'b0;
      wrap       <= 1'b0;
      running    <= 1'b0;
      edge_count <= '0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      wrap       <= wrap_nxt;
      freq_ack   <= apply;
      clk_out    <= acc_nxt[ACC_W-1];
      clk_out_8x <= acc_nxt[ACC_W-4];
      running    <= (state_nxt != IDLE);
      if (apply) fw_active <= pend_word;
      // A load in the apply cycle becomes the next pending word.
      if (freq_load)  pend_vld <= 1'b1;
      else if (apply) pend_vld <= 1'b0;
      if (acc_nxt[ACC_W-1] && !clk_out) edge_count <= edge_count + 16'd1;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (freq_load) pend_word <= freq_word;
  end

endmodule

// File: tb/tb_nco_clkgen.sv
// Scoreboard bench for nco_clkgen: per-cycle expected outputs from a behavioural
// model plus directed period/ack/stop/reset/edge-count checks.
`timescale 1ns/1ps
module tb_nco_clkgen;

  localparam int unsigned AW = 32;
  localparam logic [31:0] DFW = 32'h0800_0000;

  logic        clk_ref = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] freq_word = '0;
  logic        freq_load = 1'b0;
  logic        freq_ack, clk_out, clk_out_8x, wrap, running;
  logic [15:0] edge_count;
  logic [20:0] outv;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] m_acc, m_fw, m_pend;
  logic        m_pv, m_clk;
  logic [15:0] m_ec;
  int          m_st;
  logic [20:0] exp_q[$];

  int   rise_cnt = 0;
  logic prev_clk = 1'b0;

  nco_clkgen #(.ACC_W(AW), .DEFAULT_FW(DFW)) dut (
    .clk_ref(clk_ref), .rst(rst), .enable(enable), .freq_word(freq_word),
    .freq_load(freq_load), .freq_ack(freq_ack), .clk_out(clk_out),
    .clk_out_8x(clk_out_8x), .wrap(wrap), .running(running), .edge_count(edge_count)
  );

  assign outv = {freq_ack, clk_out, clk_out_8x, wrap, running, edge_count};

  always #5 clk_ref = ~clk_ref;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_acc = '0; m_fw = DFW; m_pend = '0; m_pv = 1'b0; m_clk = 1'b0; m_ec = '0;
    exp_q.delete();
    rise_cnt = 0; prev_clk = 1'b0;
  endtask

  // Behavioural reference: 0=IDLE 1=RUN 2=STOPPING.
  task automatic model_tick(input logic en, input logic ld, input logic [31:0] w);
    logic [32:0] s;
    logic        cy, ap, wr;
    int          nst;
    logic [31:0] nacc;
    s    = {1'b0, m_acc} + {1'b0, m_fw};
    cy   = (m_st != 0) && s[32];
    nst  = m_st; nacc = m_acc; wr = 1'b0;
    if (m_st == 0) begin
      nacc = '0;
      if (en) nst = 1;
    end else if (m_st == 1 || en) begin
      nacc = s[31:0]; wr = cy; nst = en ? 1 : 2;
    end else if (m_fw == 0 || cy) begin
      nacc = '0; wr = cy; nst = 0;
    end else begin
      nacc = s[31:0];
    end
    ap = m_pv && (wr || m_st == 0 || (m_st == 1 && m_fw == 0));
    if (nacc[31] && !m_clk) m_ec = m_ec + 16'd1;
    m_clk = nacc[31];
    if (ap) m_fw = m_pend;
    if (ld) begin m_pend = w; m_pv = 1'b1; end
    else if (ap) m_pv = 1'b0;
    m_st = nst; m_acc = nacc;
    exp_q.push_back({ap, nacc[31], nacc[28], wr, (nst != 0), m_ec});
  endtask

  task automatic step(input logic en, input logic ld, input logic [31:0] w);
    enable = en; freq_load = ld; freq_word = w;
    model_tick(en, ld, w);
    @(posedge clk_ref); #1;
    if (exp_q.size() == 0) chk("sb_empty", 1, 0);
    else chk("cycle", outv, exp_q.pop_front());
    if (clk_out && !prev_clk) rise_cnt++;
    prev_clk = clk_out;
  endtask

  task automatic period_meas(input int l1_at, input logic [31:0] l1_w,
                             input int l2_at, input logic [31:0] l2_w,
                             input int off_at, input int on_at,
                             output int len, output int hi, output int r8,
                             output int acks, output logic ack_wrap);
    logic p8, en, ld;
    logic [31:0] w;
    len = 0; hi = 0; r8 = 0; acks = 0; ack_wrap = 1'b0; p8 = clk_out_8x;
    for (int k = 0; k < 200; k++) begin
      en = !(k >= off_at && k < on_at);
      ld = (k == l1_at) || (k == l2_at);
      w  = (k == l2_at) ? l2_w : l1_w;
      step(en, ld, w);
      hi += int'(clk_out);
      if (clk_out_8x && !p8) r8++;
      p8 = clk_out_8x;
      if (freq_ack) acks++;
      if (wrap) begin len = k + 1; ack_wrap = freq_ack; break; end
    end
    if (len == 0) chk("period_timeout", 0, 1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk("rst_async", outv, 0);
    model_reset();
    @(posedge clk_ref); #1;
    rst = 1'b0;
  endtask

  int   len, hi, r8, acks, cnt, cnt2;
  logic aw;

  initial begin
    model_reset();
    repeat (2) @(posedge clk_ref);
    #1 chk("reset", outv, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

    // Default word from IDLE: one entry cycle, then 32-cycle periods.
    period_meas(-1, 0, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("first_len", len, 33);
    chk("first_edges", edge_count, 1);
    period_meas(-1, 0, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("dflt_len", len, 32);
    chk("dflt_hi", hi, 16);
    chk("dflt_8x", r8, 8);
    chk("dflt_edges", edge_count, 2);

    // Mid-period load completes the old period and acks on the wrap.
    period_meas(10, 32'h1000_0000, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("ld_old_len", len, 32);
    chk("ld_acks", acks, 1);
    chk("ld_ack_wrap", aw, 1);
    period_meas(-1, 0, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("p16_len", len, 16);
    chk("p16_hi", hi, 8);
    chk("p16_8x", r8, 8);

    // Overwritten pending word never acks.
    period_meas(3, 32'h1000_0000, 6, 32'h2000_0000, -1, -1, len, hi, r8, acks, aw);
    chk("dbl_len", len, 16);
    chk("dbl_acks", acks, 1);
    chk("dbl_ack_wrap", aw, 1);
    period_meas(-1, 0, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("p8_len", len, 8);
    chk("p8_hi", hi, 4);
    period_meas(2, DFW, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("restore_len", len, 8);
    period_meas(-1, 0, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("restore_p", len, 32);

    // Graceful stop mid-period.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, '0);
      cnt++;
      if (wrap) break;
      if (!running) cnt2++;
    end
    chk("stop_len", cnt, 22);
    chk("stop_run_hi", cnt2, 0);
    chk("stop_wrap_run", {wrap, running, clk_out}, 3'b100);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      cnt += int'(wrap) + int'(clk_out) + int'(running);
    end
    chk("idle_quiet", cnt, 0);
    period_meas(-1, 0, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("reen_len", len, 33);
    period_meas(-1, 0, -1, 0, 8, 14, len, hi, r8, acks, aw);
    chk("resume_len", len, 32);
    chk("resume_hi", hi, 16);

    // Zero word freezes the accumulator; a new word applies immediately.
    period_meas(4, 32'h0, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("zero_len", len, 32);
    chk("zero_acks", acks, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0);
      cnt += int'(wrap) + int'(clk_out) + int'(freq_ack);
    end
    chk("frozen", cnt, 0);
    period_meas(0, DFW, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("unfreeze_len", len, 34);
    chk("unfreeze_acks", acks, 1);
    chk("unfreeze_ack_wrap", aw, 0);

    // Reset mid-period discards a pending word.
    for (int i = 0; i < 10; i++) step(1'b1, (i == 3), 32'h1000_0000);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      cnt += int'(freq_ack) + int'(running);
    end
    chk("post_rst_quiet", cnt, 0);
    period_meas(-1, 0, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("post_rst_len", len, 33);
    chk("post_rst_acks", acks, 0);

    // Loads in IDLE, one coinciding with an apply: two acks back to back.
    do_reset();
    cnt = 0;
    step(1'b0, 1'b1, 32'h4000_0000); cnt += int'(freq_ack);
    step(1'b0, 1'b1, 32'h8000_0000); cnt += int'(freq_ack);
    step(1'b0, 1'b0, '0);            cnt += int'(freq_ack);
    step(1'b0, 1'b0, '0);            cnt += int'(freq_ack);
    chk("idle_acks", cnt, 2);
    period_meas(-1, 0, -1, 0, -1, -1, len, hi, r8, acks, aw);
    chk("half_len", len, 3);

    // edge_count wraps after 0x10000 rising edges.
    for (int i = 0; i < 140000 && rise_cnt < 32'hFFFF; i++) step(1'b1, 1'b0, '0);
    chk("rises_ffff", rise_cnt, 32'hFFFF);
    chk("ec_ffff", edge_count, 16'hFFFF);
    for (int i = 0; i < 10 && rise_cnt < 32'h10000; i++) step(1'b1, 1'b0, '0);
    chk("rises_10000", rise_cnt, 32'h10000);
    chk("ec_wrap", edge_count, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
